uart_frame_ctrl: RTL
====================

// Module: uart_frame_ctrl
// PURPOSE
//  Sits downstream of the UART byte receiver and consumes its rx_data/rx_done stream.
//  Parses command frames of the form HDR, ADDR, LEN, DATA[LEN], CKSUM and buffers the payload.
//  On a valid checksum, replays the payload as register writes; on any error, the frame is dropped.
//  Configures the FPGA control registers from the host MCU over the serial link.
// PARAMETERS
//  HEADER        8'hAA   frame start byte
//  MAX_LEN       16      max payload bytes (legal LEN range is 1..MAX_LEN); sizes the buffer
//  TIMEOUT_CLKS  50_000  inter-byte timeout in sys_clk cycles (1 ms at 50 MHz)
//  CNT_W         16      width of the status counters
// PORTS
//  sys_clk      in   1      system clock; the only clock
//  sys_rst      in   1      asynchronous, active-high reset
//  rx_data      in   8      received byte; valid in the cycle rx_done=1
//  rx_done      in   1      one-cycle pulse per received byte
//  wr_en        out  1      register write request
//  wr_addr      out  8      write address
//  wr_data      out  8      write data
//  wr_ready     in   1      register bank accepts; a transfer occurs when wr_en & wr_ready
//  busy         out  1      1 whenever state != S_IDLE
//  frame_ok     out  1      pulse: frame fully committed
//  err_cksum    out  1      pulse: checksum mismatch
//  err_len      out  1      pulse: LEN==0 or LEN>MAX_LEN
//  err_ovf      out  1      pulse: byte arrived during commit and was dropped
//  err_timeout  out  1      pulse: inter-byte timeout
//  frame_cnt    out  CNT_W  count of good frames; wraps
//  err_cnt      out  CNT_W  count of error pulses of all kinds; wraps
// BEHAVIOUR
//  - Reset: state=S_IDLE; every output 0; counters 0; internal index/checksum 0.
//  - Reset mid-frame aborts the frame. No write is issued after reset deasserts.
//  - States: S_IDLE, S_ADDR, S_LEN, S_DATA, S_CKSUM, S_COMMIT. All input-driven moves happen only on rx_done.
//  - S_IDLE:  rx_data==HEADER -> S_ADDR; any other byte is ignored silently.
//  - S_ADDR:  latch base=rx_data; sum=rx_data -> S_LEN.
//  - S_LEN:   0 or >MAX_LEN -> err_len and S_IDLE.
//             Otherwise latch len, sum+=rx_data, idx=0 -> S_DATA.
//  - S_DATA:  buf[idx]=rx_data, sum+=rx_data, idx++. After the byte with idx==len-1 -> S_CKSUM.
//  - S_CKSUM: rx_data==sum[7:0] -> S_COMMIT with idx=0. Otherwise err_cksum and S_IDLE.
//  - All sums are 8-bit modulo 256 and cover ADDR+LEN+DATA; HEADER is excluded.
//  - S_COMMIT: wr_en=1, wr_addr=base+idx (8-bit wrap, 8'hFF+1 -> 8'h00), wr_data=buf[idx].
//  - In S_COMMIT, outputs are held stable until wr_ready. idx advances on each transfer.
//  - After the last transfer: wr_en=0 next cycle, frame_ok=1 for 1 cycle, frame_cnt++, -> S_IDLE.
//  - Latency: the first wr_en is registered in the cycle after the CKSUM rx_done.
//  - rx_done during S_COMMIT: the byte is dropped and err_ovf pulses; the commit continues unaffected.
//  - Error pulses are registered, 1 cycle wide, and asserted the cycle after the causing event.
//  - err_cnt increments by 1 per error pulse cycle; the error conditions are mutually exclusive.
//  - A HEADER byte in a non-IDLE state is treated as ordinary data (no resync).
// CONFIGURATION
//  - Macro UART_FRAME_TIMEOUT_EN defined:
//    - Timer clears on every rx_done and counts only in S_ADDR..S_CKSUM.
//    - At TIMEOUT_CLKS-1: err_timeout pulse, -> S_IDLE, buffered payload discarded.
//    - No timeout in S_IDLE or S_COMMIT.
//  - Macro undefined: no timer logic; err_timeout tied 0; a stalled frame waits indefinitely.
// STRUCTURE
//  - Shared package uart_frame_pkg holds:
//    - state encodings S_IDLE..S_COMMIT
//    - default HEADER
//    - error-code constants (CKSUM/LEN/OVF/TIMEOUT) for status software
//  - One sub-module: uart_byte_timeout. Takes clk, rst, enable, clear; gives a timeout pulse.
//    - Instantiated only under UART_FRAME_TIMEOUT_EN.
//  - Payload buffer: MAX_LEN x 8 register array, no RAM.
// TESTING
//  1. AA 10 02 55 66 CK=CD, wr_ready=1
//     -> writes (10,55),(11,66) on consecutive cycles; frame_ok; frame_cnt=1.
//  2. Same frame, CK=00 -> no wr_en; err_cksum pulse; err_cnt=1; busy returns 0.
//  3. Noise 00 FF, then AA 20 00 -> bytes before AA ignored; err_len; then a valid frame is accepted.
//  4. AA FF 02 01 02 CK=04, wr_ready low for 3 cycles
//     -> wr_addr FF held stable, then 00; data 01,02; frame_ok once.
//  5. Byte arrives while wr_ready is stalled in commit -> err_ovf; commit completes intact.
//  6. With UART_FRAME_TIMEOUT_EN: AA 10, then idle > TIMEOUT_CLKS -> err_timeout; S_IDLE.
//     Also assert sys_rst mid-DATA -> all outputs 0 and no writes.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types for the UART command-frame controller: FSM state encoding,
// default frame header, and error codes for status software.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_CKSUM  = 3'd4,
        S_COMMIT = 3'd5
    } state_e;

    localparam logic [7:0] HEADER_DEF = 8'hAA;

    typedef enum logic [1:0] {
        ERR_CKSUM   = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_OVF     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and
// pulses timeout when the count reaches TIMEOUT_CLKS-1.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic timeout
);
    localparam int unsigned CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign timeout = enable && !clear && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || !enable || timeout) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses HDR/ADDR/LEN/DATA/CKSUM frames from the UART byte stream and replays
// the payload as register writes. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER       = HEADER_DEF,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 50_000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic             wr_en,
    output logic [7:0]       wr_addr,
    output logic [7:0]       wr_data,
    input  logic             wr_ready,
    output logic             busy,
    output logic             frame_ok,
    output logic             err_cksum,
    output logic             err_len,
    output logic             err_ovf,
    output logic             err_timeout,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    state_e             state_q, state_d;
    logic [7:0]         base_q, base_d, sum_q, sum_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d, nxt_idx;
    logic [7:0]         pbuf_q [MAX_LEN];
    logic [7:0]         pbuf_d [MAX_LEN];
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic               frame_ok_q, frame_ok_d;
    logic               err_cksum_q, err_cksum_d, err_len_q, err_len_d;
    logic               err_ovf_q, err_ovf_d, err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic               timeout_hit;

`ifdef UART_FRAME_TIMEOUT_EN
    logic tmr_en;
    assign tmr_en = (state_q inside {S_ADDR, S_LEN, S_DATA, S_CKSUM});

    uart_byte_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .enable  (tmr_en),
        .clear   (rx_done),
        .timeout (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign nxt_idx = idx_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        pbuf_d        = pbuf_q;
        wr_en_d       = wr_en_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_ok_d    = 1'b0;
        err_cksum_d   = 1'b0;
        err_len_d     = 1'b0;
        err_ovf_d     = 1'b0;
        err_timeout_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (timeout_hit) begin
            state_d       = S_IDLE;
            err_timeout_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (rx_done && rx_data == HEADER) state_d = S_ADDR;
                S_ADDR: if (rx_done) begin
                    base_d  = rx_data;
                    sum_d   = rx_data;
                    state_d = S_LEN;
                end
                S_LEN: if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = LEN_W'(rx_data);
                        sum_d   = sum_q + rx_data;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: if (rx_done) begin
                    pbuf_d[idx_q] = rx_data;
                    sum_d         = sum_q + rx_data;
                    if (LEN_W'(idx_q) == len_q - 1'b1) state_d = S_CKSUM;
                    else                               idx_d   = nxt_idx;
                end
                S_CKSUM: if (rx_done) begin
                    if (rx_data == sum_q) begin
                        // First write is staged here so wr_en appears right after the checksum byte
                        idx_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q;
                        wr_data_d = pbuf_q[0];
                        state_d   = S_COMMIT;
                    end else begin
                        err_cksum_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                S_COMMIT: begin
                    if (rx_done) err_ovf_d = 1'b1;
                    if (wr_ready) begin
                        if (LEN_W'(idx_q) == len_q - 1'b1) begin
                            wr_en_d     = 1'b0;
                            wr_addr_d   = '0;
                            wr_data_d   = '0;
                            idx_d       = '0;
                            frame_ok_d  = 1'b1;
                            frame_cnt_d = frame_cnt_q + 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            idx_d     = nxt_idx;
                            wr_addr_d = base_q + 8'(nxt_idx);
                            wr_data_d = pbuf_q[nxt_idx];
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        err_cnt_d = err_cnt_q
                  + CNT_W'(err_cksum_d | err_len_d | err_ovf_d | err_timeout_d);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            pbuf_q        <= '{default: '0};
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ok_q    <= 1'b0;
            err_cksum_q   <= 1'b0;
            err_len_q     <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            pbuf_q        <= pbuf_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_ok_q    <= frame_ok_d;
            err_cksum_q   <= err_cksum_d;
            err_len_q     <= err_len_d;
            err_ovf_q     <= err_ovf_d;
            err_timeout_q <= err_timeout_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_ok    = frame_ok_q;
    assign err_cksum   = err_cksum_q;
    assign err_len     = err_len_q;
    assign err_ovf     = err_ovf_q;
    assign err_timeout = err_timeout_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;
endmodule
